// File: rtl/gain_ramp_pkg.sv
// Shared definitions for the gain ramp controller and the volume controller it drives.
package gain_ramp_pkg;

  // Defaults shared with the volume controller instantiation (GAIN_WIDTH == its SWITCH_WIDTH).
  localparam int GAIN_WIDTH_DEF      = 16;
  localparam int STEP_DEF            = 256;
  localparam int FRAMES_PER_STEP_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    MUTED     = 2'd3
  } ramp_state_e;

  // Direction decision from the gain/target comparison; re-evaluated every clock.
  function automatic ramp_state_e next_state(input logic below, input logic above,
                                             input logic tgt_zero, input logic mute_s);
    ramp_state_e ns;
    if (below)                    ns = RAMP_UP;
    else if (above)               ns = RAMP_DOWN;
    else if (tgt_zero && mute_s)  ns = MUTED;
    else                          ns = IDLE;
    return ns;
  endfunction

endpackage

// File: rtl/frame_step_divider.sv
// Frame-tick divider: one step pulse every FRAMES_PER_STEP completed stereo frames.
// Held at zero while the ramp is parked so a new ramp always starts with a full step period.
module frame_step_divider #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic hold,
  output logic step
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

  logic [CW-1:0] div_q;
  logic [CW-1:0] div_d;

  assign step = frame_tick & ~hold & (div_q == LAST);

  // Next count: cleared while held, wraps on the step, otherwise advances per frame.
  always_comb begin
    div_d = div_q;
    if (hold)            div_d = '0;
    else if (step)       div_d = '0;
    else if (frame_tick) div_d = div_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/axis_gain_ramp_controller.sv
// Gain ramp controller: walks the volume controller's gain word toward the requested target
// in frame-aligned steps, with a soft mute that ramps to zero before reporting muted.
//
//   state     | meaning
//   IDLE      | gain_out equals target, not muted
//   RAMP_UP   | stepping gain_out up toward target
//   RAMP_DOWN | stepping gain_out down toward target
//   MUTED     | mute request completed, gain_out held at 0
module axis_gain_ramp_controller
  import gain_ramp_pkg::*;
#(
  parameter int GAIN_WIDTH      = GAIN_WIDTH_DEF,
  parameter int STEP            = STEP_DEF,
  parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  input  logic                  mute_req,
  input  logic                  frame_valid,
  input  logic                  frame_ready,
  input  logic                  frame_last,
  output logic [GAIN_WIDTH-1:0] gain_out,
  output logic                  ramp_busy,
  output logic                  muted
);

  localparam logic [GAIN_WIDTH:0]   STEP_W = (GAIN_WIDTH + 1)'(STEP);
  localparam logic [GAIN_WIDTH-1:0] STEP_N = GAIN_WIDTH'(STEP);

  logic [GAIN_WIDTH-1:0] tgt_meta_q, tgt_sync_q;
  logic                  mute_meta_q, mute_sync_q;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  ramp_state_e           state_q, state_d;
  logic                  ramp_busy_q, muted_q;

  logic [GAIN_WIDTH-1:0] tgt;
  logic [GAIN_WIDTH:0]   gain_ext, tgt_ext, up_sum, down_floor;
  logic [GAIN_WIDTH-1:0] up_val, down_val;
  logic                  gain_lt, gain_gt;
  logic                  frame_tick, hold, step;

  // Two-flop synchronisers for the switch-driven target and mute request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_meta_q  <= '0;
      tgt_sync_q  <= '0;
      mute_meta_q <= 1'b0;
      mute_sync_q <= 1'b0;
    end else begin
      tgt_meta_q  <= target_gain;
      tgt_sync_q  <= tgt_meta_q;
      mute_meta_q <= mute_req;
      mute_sync_q <= mute_meta_q;
    end
  end

  assign tgt        = mute_sync_q ? '0 : tgt_sync_q;
  assign frame_tick = frame_valid & frame_ready & frame_last;
  assign hold       = (state_q == IDLE) || (state_q == MUTED);

  frame_step_divider #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_divider (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .hold       (hold),
    .step       (step)
  );

  // Saturating step arithmetic in one extra bit so neither end of the code range wraps.
  assign gain_ext   = {1'b0, gain_q};
  assign tgt_ext    = {1'b0, tgt};
  assign up_sum     = gain_ext + STEP_W;
  assign down_floor = tgt_ext + STEP_W;
  assign up_val     = (up_sum >= tgt_ext) ? tgt : up_sum[GAIN_WIDTH-1:0];
  assign down_val   = (gain_ext >= down_floor) ? (gain_q - STEP_N) : tgt;
  assign gain_lt    = gain_q < tgt;
  assign gain_gt    = gain_q > tgt;

  assign state_d = next_state(gain_lt, gain_gt, (tgt == '0), mute_sync_q);

  // Gain only moves on a step and only in the direction the current state and target agree on,
  // so a target that crosses gain_out flips the state without a spurious update.
  always_comb begin
    gain_d = gain_q;
    if (step && (state_q == RAMP_UP) && gain_lt)        gain_d = up_val;
    else if (step && (state_q == RAMP_DOWN) && gain_gt) gain_d = down_val;
  end

  // FSM with registered gain and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MUTED;
      gain_q      <= '0;
      ramp_busy_q <= 1'b0;
      muted_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      ramp_busy_q <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
      muted_q     <= (state_d == MUTED);
    end
  end

  assign gain_out  = gain_q;
  assign ramp_busy = ramp_busy_q;
  assign muted     = muted_q;

endmodule

// File: tb/tb_axis_gain_ramp_controller.sv
// Bench for the gain ramp controller: reset, directed ramp scenarios, a settle table and
// random traffic compared every cycle against a frame-counting reference model.
module tb_axis_gain_ramp_controller;

  localparam int GW   = 16;
  localparam int STEP = 256;
  localparam int FPS  = 4;

  logic          clk, rst;
  logic [GW-1:0] target_gain;
  logic          mute_req, frame_valid, frame_ready, frame_last;
  logic [GW-1:0] gain_out;
  logic          ramp_busy, muted;

  axis_gain_ramp_controller #(
    .GAIN_WIDTH(GW), .STEP(STEP), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .target_gain (target_gain),
    .mute_req    (mute_req),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_last  (frame_last),
    .gain_out    (gain_out),
    .ramp_busy   (ramp_busy),
    .muted       (muted)
  );

  typedef struct {
    logic [GW-1:0] tgt;
    logic          mute;
    logic [GW-1:0] exp_gain;
    logic          exp_muted;
  } vec_t;

  vec_t          tbl[8];
  int            n_checks = 0;
  int            n_pass = 0;
  int            fmode;
  bit            beat;
  bit            chk_en;
  int            tick_cnt, chg_cnt;
  logic [GW-1:0] max_gain;

  // Reference model state: gain as an integer, ramp direction, frames counted this step,
  // and a two-deep delay line standing in for the synchronisers.
  int m_gain, m_dir, m_div, p_t0, p_t1;
  bit m_muted, p_m0, p_m1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int t, g0;
    bit stp;
    t   = p_m1 ? 0 : p_t1;
    g0  = m_gain;
    stp = 1'b0;
    if (m_dir == 0) m_div = 0;
    else if (frame_valid && frame_ready && frame_last) begin
      if (m_div == FPS - 1) begin
        stp   = 1'b1;
        m_div = 0;
      end else m_div++;
    end
    if (stp && m_dir > 0 && g0 < t)      m_gain = (g0 + STEP > t) ? t : g0 + STEP;
    else if (stp && m_dir < 0 && g0 > t) m_gain = (g0 - STEP < t) ? t : g0 - STEP;
    m_dir   = (g0 < t) ? 1 : ((g0 > t) ? -1 : 0);
    m_muted = (g0 == t) && (t == 0) && p_m1;
    p_t1 = p_t0;
    p_m1 = p_m0;
    p_t0 = int'(target_gain);
    p_m0 = mute_req;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_gain = 0; m_dir = 0; m_div = 0; m_muted = 1'b1;
      p_t0 = 0; p_t1 = 0; p_m0 = 1'b0; p_m1 = 1'b0;
    end else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      chk("model_gain", int'(gain_out), m_gain);
      chk("model_busy", int'(ramp_busy), (m_dir != 0) ? 1 : 0);
      chk("model_muted", int'(muted), int'(m_muted));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n clocks; counts frames consumed while ramping and gain changes, drives frames.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      bit pb, pt;
      logic [GW-1:0] pg;
      pb = ramp_busy;
      pt = frame_valid & frame_ready & frame_last;
      pg = gain_out;
      @(posedge clk);
      #1;
      if (pb && pt) tick_cnt++;
      if (gain_out != pg) chg_cnt++;
      if (gain_out > max_gain) max_gain = gain_out;
      case (fmode)
        1: begin
          frame_valid = 1'b1; frame_ready = 1'b1; frame_last = beat; beat = ~beat;
        end
        2: begin
          frame_valid = 1'($urandom_range(0, 1));
          frame_ready = ($urandom_range(0, 3) != 0);
          frame_last  = 1'($urandom_range(0, 1));
        end
        default: begin
          frame_valid = 1'b0; frame_ready = 1'b1; frame_last = 1'b0;
        end
      endcase
    end
  endtask

  task automatic wait_gain(input logic [GW-1:0] v, input int maxc, input string nm);
    int i;
    i = 0;
    while (gain_out != v && i < maxc) begin
      cyc(1);
      i++;
    end
    chk({nm, "_reached"}, int'(gain_out == v), 1);
  endtask

  initial begin
    rst = 1'b1; target_gain = '0; mute_req = 1'b0;
    frame_valid = 1'b0; frame_ready = 1'b0; frame_last = 1'b0;
    fmode = 0; beat = 1'b0; chk_en = 1'b1;
    tick_cnt = 0; chg_cnt = 0; max_gain = '0;

    tbl[0] = '{16'h0300, 1'b0, 16'h0300, 1'b0};
    tbl[1] = '{16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{16'h0155, 1'b0, 16'h0155, 1'b0};
    tbl[3] = '{16'h0155, 1'b1, 16'h0000, 1'b1};
    tbl[4] = '{16'h00FF, 1'b0, 16'h00FF, 1'b0};
    tbl[5] = '{16'h0001, 1'b0, 16'h0001, 1'b0};
    tbl[6] = '{16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[7] = '{16'h0400, 1'b0, 16'h0400, 1'b0};

    cyc(3);
    chk("rst_gain", int'(gain_out), 0);
    chk("rst_muted", int'(muted), 1);
    chk("rst_busy", int'(ramp_busy), 0);

    // Soft start from reset with 2-word frames streaming.
    target_gain = 16'h0800;
    fmode = 1;
    cyc(2);
    rst = 1'b0;
    tick_cnt = 0; chg_cnt = 0;
    wait_gain(16'h0800, 400, "soft_start");
    chk("soft_start_frames", tick_cnt, 32);
    chk("soft_start_steps", chg_cnt, 8);
    chk("soft_start_busy_at_land", int'(ramp_busy), 1);
    cyc(1);
    chk("soft_start_busy_after", int'(ramp_busy), 0);
    chk("soft_start_muted", int'(muted), 0);
    chk("soft_start_gain", int'(gain_out), 'h0800);

    // Partial step.
    target_gain = 16'h0880;
    tick_cnt = 0; chg_cnt = 0;
    wait_gain(16'h0880, 200, "partial");
    chk("partial_steps", chg_cnt, 1);
    chk("partial_frames", tick_cnt, 4);
    cyc(1);
    chk("partial_idle", int'(ramp_busy), 0);

    // Max code without wrap.
    target_gain = 16'hFF80;
    wait_gain(16'hFF80, 3000, "to_ff80");
    target_gain = 16'hFFFF;
    chg_cnt = 0;
    wait_gain(16'hFFFF, 200, "max_code");
    chk("max_code_steps", chg_cnt, 1);
    cyc(2);
    chk("max_code_hold", int'(gain_out), 'hFFFF);
    chk("max_code_idle", int'(ramp_busy), 0);

    // Mute round trip from 0x0400.
    target_gain = 16'h0400;
    wait_gain(16'h0400, 3000, "to_0400");
    cyc(2);
    mute_req = 1'b1;
    chg_cnt = 0;
    wait_gain(16'h0000, 200, "mute_down");
    chk("mute_down_steps", chg_cnt, 4);
    chk("mute_not_yet", int'(muted), 0);
    cyc(1);
    chk("mute_done", int'(muted), 1);
    chk("mute_busy", int'(ramp_busy), 0);
    mute_req = 1'b0;
    cyc(2);
    chk("unmute_latency_muted", int'(muted), 1);
    cyc(1);
    chk("unmute_muted_clear", int'(muted), 0);
    chk("unmute_busy", int'(ramp_busy), 1);
    chg_cnt = 0; tick_cnt = 0;
    wait_gain(16'h0400, 200, "unmute_up");
    chk("unmute_steps", chg_cnt, 4);
    chk("unmute_frames", tick_cnt, 16);
    cyc(1);
    chk("unmute_idle", int'(ramp_busy), 0);

    // Reversal mid-ramp keeps the divider phase.
    target_gain = 16'h1000;
    wait_gain(16'h0600, 200, "rev_up");
    tick_cnt = 0; chg_cnt = 0; max_gain = 16'h0600;
    cyc(1);
    target_gain = 16'h0300;
    wait_gain(16'h0500, 200, "rev_0500");
    chk("rev_frames", tick_cnt, 4);
    chk("rev_first_steps", chg_cnt, 1);
    wait_gain(16'h0400, 200, "rev_0400");
    wait_gain(16'h0300, 200, "rev_0300");
    chk("rev_steps", chg_cnt, 3);
    chk("rev_max", int'(max_gain), 'h0600);
    cyc(1);
    chk("rev_idle", int'(ramp_busy), 0);

    // Settle table.
    for (int i = 0; i < 8; i++) begin
      int j;
      target_gain = tbl[i].tgt;
      mute_req = tbl[i].mute;
      cyc(4);
      j = 0;
      while (ramp_busy && j < 3000) begin
        cyc(1);
        j++;
      end
      cyc(2);
      chk($sformatf("tbl%0d_gain", i), int'(gain_out), int'(tbl[i].exp_gain));
      chk($sformatf("tbl%0d_muted", i), int'(muted), int'(tbl[i].exp_muted));
      chk($sformatf("tbl%0d_busy", i), int'(ramp_busy), 0);
    end

    // Frame stall then asynchronous reset mid-ramp.
    target_gain = 16'h2000;
    wait_gain(16'h0500, 200, "stall_ramp");
    fmode = 0;
    frame_valid = 1'b0; frame_last = 1'b0;
    chg_cnt = 0;
    cyc(1000);
    chk("stall_changes", chg_cnt, 0);
    chk("stall_gain", int'(gain_out), 'h0500);
    chk("stall_busy", int'(ramp_busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gain", int'(gain_out), 0);
    chk("async_rst_muted", int'(muted), 1);
    chk("async_rst_busy", int'(ramp_busy), 0);
    cyc(2);
    rst = 1'b0;

    // Random targets, mutes and frame traffic against the model.
    fmode = 2;
    for (int s = 0; s < 30; s++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      target_gain = 16'($urandom_range(0, 16'hFFFF));
      else if (sel == 1) target_gain = 16'($urandom_range(16'hFE00, 16'hFFFF));
      else               target_gain = 16'($urandom_range(0, 16'h0C00));
      mute_req = ($urandom_range(0, 4) == 0);
      cyc(int'($urandom_range(20, 600)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
